matrix_key_scan: RTL

Parametrised successor to the fixed 4x4 scanner. It scans a ROWS x COLS active-low key matrix and debounces whole frames. Its outputs are a per-key state bitmap, press/release event pulses with key codes, and a multi-key flag. It sits between the board matrix pins and the application logic, such as the display or calculator datapath.

---
 rtl/matrix_key_pkg.sv | 27 ++
 rtl/matrix_key_scan_debounce.sv | 117 +++++++++++
 rtl/matrix_key_scan.sv | 116 +++++++++++
 3 files changed

// File: rtl/matrix_key_pkg.sv
// rtl/matrix_key_pkg.sv - shared types and helpers for the matrix key scanner
package matrix_key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EVAL = 2'd2
    } scan_state_e;

    // Width of a key index for n keys; never narrower than one bit.
    function automatic int key_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic int lowest_set(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/matrix_key_scan_debounce.sv
// rtl/matrix_key_scan_debounce.sv - frame capture, whole-frame debounce and key events
module matrix_frame_debounce
    import matrix_key_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DEBOUNCE = 2,
    localparam int N       = ROWS * COLS,
    localparam int KW      = key_width(ROWS * COLS),
    localparam int RW      = key_width(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_stb,
    input  logic [RW-1:0] sample_row,
    input  logic [COLS-1:0] col,
    input  logic          eval_stb,
    output logic [N-1:0]  key_state,
    output logic          key_valid,
    output logic [KW-1:0] key_code,
    output logic          press_evt,
    output logic [KW-1:0] press_code,
    output logic          release_evt,
    output logic          multi
);

    logic [N-1:0]  raw_q, raw_d;
    logic [N-1:0]  prev_raw_q, prev_raw_d;
    logic [3:0]    stable_q, stable_d;
    logic [N-1:0]  key_state_q, key_state_d;
    logic [N-1:0]  old_state_q, old_state_d;
    logic          key_valid_q, key_valid_d;
    logic [KW-1:0] key_code_q, key_code_d;
    logic          press_evt_q, press_evt_d;
    logic [KW-1:0] press_code_q, press_code_d;
    logic          release_evt_q, release_evt_d;
    logic          multi_q, multi_d;

    // Capture one row of columns per slot, then judge the whole frame at EVAL.
    always_comb begin
        raw_d       = raw_q;
        prev_raw_d  = prev_raw_q;
        stable_d    = stable_q;
        key_state_d = key_state_q;
        if (sample_stb) begin
            raw_d[int'(sample_row) * COLS +: COLS] = ~col;
        end
        if (eval_stb) begin
            if (raw_q == prev_raw_q) begin
                stable_d = (stable_q == 4'(DEBOUNCE)) ? stable_q : stable_q + 4'd1;
            end else begin
                stable_d = 4'd0;
            end
            prev_raw_d = raw_q;
            if ((stable_d == 4'(DEBOUNCE)) && (raw_q != key_state_q)) begin
                key_state_d = raw_q;
            end
        end
    end

    // Edge detect against last cycle's key_state and derive the summary outputs.
    always_comb begin
        logic [N-1:0] newly;
        logic [63:0]  ks64;
        logic [63:0]  nw64;
        newly          = key_state_q & ~old_state_q;
        ks64           = '0;
        nw64           = '0;
        ks64[N-1:0]    = key_state_q;
        nw64[N-1:0]    = newly;
        old_state_d    = key_state_q;
        press_evt_d    = |newly;
        press_code_d   = KW'(lowest_set(nw64));
        release_evt_d  = |(old_state_q & ~key_state_q);
        key_valid_d    = |key_state_q;
        key_code_d     = KW'(lowest_set(ks64));
        multi_d        = (key_state_q & (key_state_q - N'(1))) != '0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q         <= '0;
            prev_raw_q    <= '0;
            stable_q      <= '0;
            key_state_q   <= '0;
            old_state_q   <= '0;
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            press_evt_q   <= 1'b0;
            press_code_q  <= '0;
            release_evt_q <= 1'b0;
            multi_q       <= 1'b0;
        end else begin
            raw_q         <= raw_d;
            prev_raw_q    <= prev_raw_d;
            stable_q      <= stable_d;
            key_state_q   <= key_state_d;
            old_state_q   <= old_state_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            press_evt_q   <= press_evt_d;
            press_code_q  <= press_code_d;
            release_evt_q <= release_evt_d;
            multi_q       <= multi_d;
        end
    end

    assign key_state   = key_state_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign press_evt   = press_evt_q;
    assign press_code  = press_code_q;
    assign release_evt = release_evt_q;
    assign multi       = multi_q;

endmodule

// File: rtl/matrix_key_scan.sv
// rtl/matrix_key_scan.sv - row scan FSM and slot timing for the key matrix
module matrix_key_scan
    import matrix_key_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 250000,
    parameter int DEBOUNCE = 2,
    localparam int KW      = key_width(ROWS * COLS)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [COLS-1:0]      col,
    output logic [ROWS-1:0]      row,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 key_valid,
    output logic [KW-1:0]        key_code,
    output logic                 press_evt,
    output logic [KW-1:0]        press_code,
    output logic                 release_evt,
    output logic                 multi
);

    localparam int RW = key_width(ROWS);
    localparam int SW = key_width(SCAN_DIV);

    scan_state_e   state_q, state_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          sample_stb;
    logic          eval_stb;

    // Next-state logic: walk every row slot, then spend one cycle on EVAL.
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        slot_d     = slot_q;
        sample_stb = 1'b0;
        eval_stb   = 1'b0;
        case (state_q)
            IDLE: begin
                row_idx_d = '0;
                slot_d    = '0;
                if (en) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                sample_stb = (slot_q == SW'(SCAN_DIV / 2 - 1));
                if (slot_q == SW'(SCAN_DIV - 1)) begin
                    slot_d = '0;
                    if (row_idx_q == RW'(ROWS - 1)) begin
                        row_idx_d = '0;
                        state_d   = EVAL;
                    end else begin
                        row_idx_d = row_idx_q + RW'(1);
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            EVAL: begin
                eval_stb  = 1'b1;
                row_idx_d = '0;
                slot_d    = '0;
                state_d   = en ? SCAN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, row index and slot counter registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_idx_q <= '0;
            slot_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            slot_q    <= slot_d;
        end
    end

    // Active-low one-hot drive only while scanning.
    always_comb begin
        row = '1;
        if (state_q == SCAN) begin
            row[row_idx_q] = 1'b0;
        end
    end

    matrix_frame_debounce #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk         (sys_clk),
        .rst         (rst),
        .sample_stb  (sample_stb),
        .sample_row  (row_idx_q),
        .col         (col),
        .eval_stb    (eval_stb),
        .key_state   (key_state),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .press_evt   (press_evt),
        .press_code  (press_code),
        .release_evt (release_evt),
        .multi       (multi)
    );

endmodule
